dmem_result_capture: RTL and testbench

Passive snooper on the CPU data-memory write port (`d_mem_addr`/`d_mem_wdata`/`d_mem_wen`, in parallel with the data RAM). It captures full-word stores into two result windows (DFT results at 0x400, frequency energy at 0x500) and queues them as tagged entries in a FIFO drained over a valid/ready stream. It also tracks per-window coverage and raises `done` once every word of both windows has been written. This replaces bench-side write monitoring with synthesizable logic usable on FPGA.

---
 rtl/dmem_result_capture_pkg.sv | 31 +++
 rtl/dmem_result_capture_sync_fifo.sv | 63 ++++++
 rtl/dmem_result_capture.sv | 159 +++++++++++++++
 tb/tb_dmem_result_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_result_capture_pkg.sv
// Shared capture definitions: window IDs, FIFO entry layout, default window bases,
// FSM state encodings and a saturating increment helper.
package dmem_result_capture_pkg;

   localparam logic        WIN_DFT  = 1'b0;
   localparam logic        WIN_FREQ = 1'b1;

   localparam int          IDX_W    = 5;
   localparam int          DATA_W   = 32;
   localparam int          ENTRY_W  = 1 + IDX_W + DATA_W;
   localparam int          CNT_W    = 16;

   localparam logic [31:0] DEF_WIN0_BASE = 32'h0000_0400;
   localparam logic [31:0] DEF_WIN1_BASE = 32'h0000_0500;

   typedef enum logic {
      ST_CAPTURE  = 1'b0,
      ST_COMPLETE = 1'b1
   } cap_state_t;

   typedef struct packed {
      logic              win;
      logic [IDX_W-1:0]  index;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_result_capture_sync_fifo.sv
// Registered synchronous FIFO with simultaneous push/pop; a push that finds the
// FIFO full is refused unless a pop frees the slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && !push_ok;

   // Head is gated while empty so the outputs read zero out of reset.
   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_result_capture.sv
// Passive data-memory write snooper: captures full-word stores into two result
// windows, queues them as tagged entries and flags completion of both windows.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_CAPTURE  | collecting stores, at least one window word still unseen
//   ST_COMPLETE | every word of both windows written; done=1, still capturing
module dmem_result_capture
   import dmem_result_capture_pkg::*;
#(
   parameter logic [31:0] WIN0_BASE  = DEF_WIN0_BASE,
   parameter logic [31:0] WIN1_BASE  = DEF_WIN1_BASE,
   parameter int          WIN_WORDS  = 12,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic [31:0] d_mem_addr,
   input  logic [31:0] d_mem_wdata,
   input  logic [3:0]  d_mem_wen,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_win,
   output logic [4:0]  out_index,
   output logic [31:0] out_data,
   output logic [15:0] win0_count,
   output logic [15:0] win1_count,
   output logic [15:0] drop_count,
   output logic        overflow,
   output logic        done
);

   localparam logic [31:0] WIN_BYTES = 32'(4 * WIN_WORDS);

   cap_state_t           state;
   cap_state_t           state_nxt;

   logic [31:0]          off0;
   logic [31:0]          off1;
   logic                 word_store;
   logic                 in0;
   logic                 in1;
   logic                 hit0;
   logic                 hit1;
   logic                 push;
   logic [IDX_W-1:0]     idx0;
   logic [IDX_W-1:0]     idx1;
   entry_t               push_entry;
   entry_t               head;
   logic [ENTRY_W-1:0]   fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_drop;
   logic                 pop;

   logic [WIN_WORDS-1:0] cov0;
   logic [WIN_WORDS-1:0] cov1;
   logic [WIN_WORDS-1:0] cov0_nxt;
   logic [WIN_WORDS-1:0] cov1_nxt;

   // Address decode; subtraction wraps below BASE, so the range check also
   // rejects addresses under the window.
   assign off0       = d_mem_addr - WIN0_BASE;
   assign off1       = d_mem_addr - WIN1_BASE;
   assign word_store = (d_mem_wen == 4'b1111) && (d_mem_addr[1:0] == 2'b00);
   assign in0        = (d_mem_addr >= WIN0_BASE) && (off0 < WIN_BYTES);
   assign in1        = (d_mem_addr >= WIN1_BASE) && (off1 < WIN_BYTES);
   assign hit0       = word_store && in0 && !clr;
   assign hit1       = word_store && in1 && !in0 && !clr;
   assign push       = hit0 || hit1;
   assign idx0       = off0[IDX_W+1:2];
   assign idx1       = off1[IDX_W+1:2];

   always_comb begin
      push_entry       = '0;
      push_entry.win   = hit0 ? WIN_DFT : WIN_FREQ;
      push_entry.index = hit0 ? idx0 : idx1;
      push_entry.data  = d_mem_wdata;
   end

   assign cov0_nxt = cov0 | (hit0 ? (WIN_WORDS'(1) << idx0) : '0);
   assign cov1_nxt = cov1 | (hit1 ? (WIN_WORDS'(1) << idx1) : '0);

   assign pop = out_valid && out_ready;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   assign head      = entry_t'(fifo_dout);
   assign out_valid = !fifo_empty;
   assign out_win   = head.win;
   assign out_index = head.index;
   assign out_data  = head.data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cov0       <= '0;
         cov1       <= '0;
         win0_count <= '0;
         win1_count <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else if (clr) begin
         cov0       <= '0;
         cov1       <= '0;
         win0_count <= '0;
         win1_count <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         cov0 <= cov0_nxt;
         cov1 <= cov1_nxt;
         if (hit0)      win0_count <= sat_inc(win0_count);
         if (hit1)      win1_count <= sat_inc(win1_count);
         if (fifo_drop) begin
            drop_count <= sat_inc(drop_count);
            overflow   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CAPTURE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ST_CAPTURE;
      end else begin
         case (state)
            ST_CAPTURE:  if ((&cov0_nxt) && (&cov1_nxt)) state_nxt = ST_COMPLETE;
            ST_COMPLETE: state_nxt = ST_COMPLETE;
            default:     state_nxt = ST_CAPTURE;
         endcase
      end
   end

   assign done = (state == ST_COMPLETE);

endmodule

// File: tb/tb_dmem_result_capture.sv
// Directed bench for dmem_result_capture with hand-computed expectations.
module tb_dmem_result_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [31:0] d_mem_addr;
   logic [31:0] d_mem_wdata;
   logic [3:0]  d_mem_wen;
   logic        out_valid;
   logic        out_ready;
   logic        out_win;
   logic [4:0]  out_index;
   logic [31:0] out_data;
   logic [15:0] win0_count;
   logic [15:0] win1_count;
   logic [15:0] drop_count;
   logic        overflow;
   logic        done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_result_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .d_mem_addr  (d_mem_addr),
      .d_mem_wdata (d_mem_wdata),
      .d_mem_wen   (d_mem_wen),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_win     (out_win),
      .out_index   (out_index),
      .out_data    (out_data),
      .win0_count  (win0_count),
      .win1_count  (win1_count),
      .drop_count  (drop_count),
      .overflow    (overflow),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic v, input logic w,
                           input logic [4:0] idx, input logic [31:0] data);
      chk(tag, {25'd0, out_valid, out_win, out_index, out_data}, {25'd0, v, w, idx, data});
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk(tag, {out_valid, out_win, out_index, out_data, win0_count, win1_count,
                drop_count, overflow, done}, 64'd0);
   endtask

   // One clock of stimulus: drive on the falling edge, settle past the rising edge.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      @(negedge clk);
      d_mem_addr  = a;
      d_mem_wdata = d;
      d_mem_wen   = w;
      @(posedge clk);
      #1;
      d_mem_wen = 4'h0;
   endtask

   initial begin
      int order [12] = '{5, 5, 11, 10, 9, 8, 7, 6, 4, 3, 2, 1};
      int drain [8]  = '{1, 2, 3, 4, 5, 6, 7, 10};

      rst_n       = 1'b0;
      clr         = 1'b0;
      d_mem_addr  = '0;
      d_mem_wdata = '0;
      d_mem_wen   = 4'h0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;

      // Single store appears one edge later, then drains.
      out_ready = 1'b1;
      cyc(32'h400, 32'h0000_0064, 4'hF);
      chk_head("first_entry", 1'b1, 1'b0, 5'd0, 32'h64);
      chk("first_win0_count", win0_count, 16'd1);
      cyc(32'h0, 32'h0, 4'h0);
      chk("first_popped", out_valid, 1'b0);

      // Partial, misaligned and out-of-window stores are ignored.
      cyc(32'h404, 32'h1111_1111, 4'b0011);
      cyc(32'h402, 32'h2222_2222, 4'hF);
      cyc(32'h430, 32'h3333_3333, 4'hF);
      cyc(32'h4FC, 32'h4444_4444, 4'hF);
      chk("ignored_no_entry", out_valid, 1'b0);
      chk("ignored_counts", {win0_count, win1_count, drop_count}, {16'd1, 16'd0, 16'd0});

      // Ten window-1 stores into a depth-8 FIFO with no consumer.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) cyc(32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      chk("burst_win1_count", win1_count, 16'd10);
      chk("burst_drop_count", drop_count, 16'd2);
      chk("burst_overflow", overflow, 1'b1);
      chk_head("burst_head", 1'b1, 1'b1, 5'd0, 32'hA000_0000);

      // Full FIFO with pop and push on the same edge: no drop.
      out_ready = 1'b1;
      cyc(32'h528, 32'hA000_000A, 4'hF);
      chk("pushpop_no_drop", drop_count, 16'd2);
      chk_head("pushpop_head", 1'b1, 1'b1, 5'd1, 32'hA000_0001);
      // Still full: the next unconsumed store must drop.
      out_ready = 1'b0;
      cyc(32'h52C, 32'hA000_000B, 4'hF);
      chk("still_full_drop", drop_count, 16'd3);
      chk("still_full_win1_count", win1_count, 16'd12);

      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk_head($sformatf("drain_%0d", k), 1'b1, 1'b1, 5'(drain[k]),
                  32'hA000_0000 + 32'(drain[k]));
         cyc(32'h0, 32'h0, 4'h0);
      end
      chk("drain_empty", out_valid, 1'b0);
      chk("done_not_yet", done, 1'b0);

      // Complete window 0 (index 0 already seen), with one duplicate.
      for (int i = 0; i < 12; i++) begin
         if (i == 11) chk("done_before_last", done, 1'b0);
         cyc(32'h400 + 32'(4 * order[i]), 32'hB000_0000 + 32'(i), 4'hF);
         chk_head($sformatf("win0_entry_%0d", i), 1'b1, 1'b0, 5'(order[i]),
                  32'hB000_0000 + 32'(i));
      end
      chk("done_after_last", done, 1'b1);
      chk("win0_count_13", win0_count, 16'd13);
      chk("complete_keeps_capturing", {win1_count, drop_count}, {16'd12, 16'd3});
      cyc(32'h504, 32'hC000_0001, 4'hF);
      chk_head("complete_queues", 1'b1, 1'b1, 5'd1, 32'hC000_0001);
      chk("done_held", done, 1'b1);

      // Clear coincident with a hit: hit discarded, back to CAPTURE.
      out_ready = 1'b0;
      cyc(32'h508, 32'hC000_0002, 4'hF);
      clr = 1'b1;
      cyc(32'h400, 32'hD000_0000, 4'hF);
      clr = 1'b0;
      chk_idle_outputs("clr_with_hit");
      cyc(32'h0, 32'h0, 4'h0);
      chk_idle_outputs("clr_settled");

      cyc(32'h52C, 32'hE000_000B, 4'hF);
      chk_head("post_clr_entry", 1'b1, 1'b1, 5'd11, 32'hE000_000B);
      chk("post_clr_win1_count", win1_count, 16'd1);

      // Asynchronous reset in the middle of a burst.
      cyc(32'h400, 32'hF000_0000, 4'hF);
      cyc(32'h404, 32'hF000_0001, 4'hF);
      @(negedge clk);
      d_mem_addr  = 32'h408;
      d_mem_wdata = 32'hF000_0002;
      d_mem_wen   = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_reset_mid_burst");
      @(posedge clk);
      #1;
      chk_idle_outputs("async_reset_held");
      @(negedge clk);
      d_mem_wen = 4'h0;
      rst_n     = 1'b1;
      cyc(32'h400, 32'h0000_0077, 4'hF);
      chk_head("after_reset_entry", 1'b1, 1'b0, 5'd0, 32'h77);
      chk("after_reset_done", done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
